// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit sequencer.
//   state_t      sequencer FSM states
//   TL_GET/TL_PUT_F  TileLink A-channel opcodes used by the sequencer
//   UART_THR/UART_LSR  register offsets inside the uart slave
//   LSR_THRE     bit index of "transmit holding register empty" in LSR
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POLL_REQ = 3'd1,
      S_POLL_RSP = 3'd2,
      S_PUT_REQ  = 3'd3,
      S_PUT_RSP  = 3'd4
   } state_t;

   localparam logic [2:0]  TL_PUT_F = 3'd0;
   localparam logic [2:0]  TL_GET   = 3'd4;

   localparam logic [63:0] UART_THR = 64'd0;
   localparam logic [63:0] UART_LSR = 64'd5;

   localparam int LSR_THRE    = 5;
   localparam int TL_SOURCE_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extended pointers.
//   clk, rst_n     clock, async active-low reset (pointers only)
//   push, wdata    write request; ignored while full
//   pop            read request; ignored while empty
//   rdata          head entry (valid while !empty)
//   full, empty    status
//   level          number of stored entries
// Pointers carry one extra bit so full and empty differ only in the MSB.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign level   = wptr - rptr;
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: TileLink master that drains a byte FIFO into a uart.
// For every byte it polls LSR (GET) until THRE is set, then writes THR
// (PutFullData). The byte is popped only when the PUT is acknowledged.
//   clk, rst_n           clock, async active-low reset
//   tx_valid/tx_ready/tx_data   byte source handshake
//   busy                 FIFO non-empty or FSM not idle
//   err, err_clr         sticky response error flag and its clear
//   a_*, d_*             TileLink A (out) and D (in) channels, d_ready out
// Optional build macro UART_TX_CRLF_EN: a 0x0A byte is preceded on the wire
// by a 0x0D; the extra PUT does not pop the FIFO.
//
// state       | meaning
// S_IDLE      | FIFO empty, nothing in flight
// S_POLL_REQ  | GET of LSR offered on channel A
// S_POLL_RSP  | waiting for LSR data on channel D
// S_PUT_REQ   | PutFullData of head byte to THR offered on channel A
// S_PUT_RSP   | waiting for the AccessAck of the PUT
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter int                     FIFO_DEPTH = 8,
   parameter logic [TL_SOURCE_W-1:0] SOURCE_ID  = '0,
   parameter logic [63:0]            UART_BASE  = 64'h0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic [7:0]             tx_data,
   output logic                   busy,
   output logic                   err,
   input  logic                   err_clr,
   output logic                   a_valid,
   input  logic                   a_ready,
   output logic [2:0]             a_opcode,
   output logic [63:0]            a_address,
   output logic [63:0]            a_data,
   output logic [2:0]             a_size,
   output logic [TL_SOURCE_W-1:0] a_source,
   input  logic                   d_valid,
   output logic                   d_ready,
   input  logic [63:0]            d_data,
   input  logic                   d_denied,
   input  logic [TL_SOURCE_W-1:0] d_source
);

   localparam int AW = $clog2(FIFO_DEPTH);

   state_t       state;
   state_t       state_nxt;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic [7:0]   head;
   logic [AW:0]  level;
   logic         rsp_bad;
   logic         rsp_bad_evt;
   logic         still_nonempty;
   logic         expand;
   logic         cr_set;
   logic [7:0]   put_byte;
   logic         unused_d_data;

   assign tx_ready = !full;
   assign push     = tx_valid && tx_ready;
   assign busy     = !empty || (state != S_IDLE);
   assign a_size   = 3'd0;
   assign a_source = SOURCE_ID;
   assign rsp_bad  = d_denied || (d_source != SOURCE_ID);

   // A byte pushed in the same cycle as the last pop keeps the FSM polling.
   assign still_nonempty = (level > {{AW{1'b0}}, 1'b1}) || push;

   assign unused_d_data = ^{d_data[63:LSR_THRE+1], d_data[LSR_THRE-1:0]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (tx_data),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

`ifdef UART_TX_CRLF_EN
   logic cr_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cr_done <= 1'b0;
      else if (pop)    cr_done <= 1'b0;
      else if (cr_set) cr_done <= 1'b1;
   end

   assign expand   = (head == 8'h0A) && !cr_done;
   assign put_byte = expand ? 8'h0D : head;
`else
   logic unused_cr_set;

   assign expand        = 1'b0;
   assign put_byte      = head;
   assign unused_cr_set = cr_set;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      a_valid     = 1'b0;
      a_opcode    = TL_GET;
      a_address   = UART_BASE + UART_LSR;
      a_data      = '0;
      d_ready     = 1'b0;
      pop         = 1'b0;
      cr_set      = 1'b0;
      rsp_bad_evt = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) state_nxt = S_POLL_REQ;
         end
         S_POLL_REQ: begin
            a_valid = 1'b1;
            if (a_ready) state_nxt = S_POLL_RSP;
         end
         S_POLL_RSP: begin
            d_ready = 1'b1;
            if (d_valid) begin
               if (rsp_bad) begin
                  rsp_bad_evt = 1'b1;
                  state_nxt   = S_POLL_REQ;
               end else if (d_data[LSR_THRE]) begin
                  state_nxt = S_PUT_REQ;
               end else begin
                  state_nxt = S_POLL_REQ;
               end
            end
         end
         S_PUT_REQ: begin
            a_valid   = 1'b1;
            a_opcode  = TL_PUT_F;
            a_address = UART_BASE + UART_THR;
            a_data    = {56'b0, put_byte};
            if (a_ready) state_nxt = S_PUT_RSP;
         end
         S_PUT_RSP: begin
            d_ready = 1'b1;
            if (d_valid) begin
               if (rsp_bad) begin
                  rsp_bad_evt = 1'b1;
                  state_nxt   = S_POLL_REQ;
               end else if (expand) begin
                  cr_set    = 1'b1;
                  state_nxt = S_POLL_REQ;
               end else begin
                  pop       = 1'b1;
                  state_nxt = still_nonempty ? S_POLL_REQ : S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           err <= 1'b0;
      else if (rsp_bad_evt) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
   end

endmodule
